// File: rtl/slave_port_mux.sv
// Per-slave port multiplexer: forwards the arbiter-granted master's request to one slave
// and routes the acknowledge, read data or timeout error back to that master.
module slave_port_mux #(
    parameter int         SLAVE   = 0,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         arb_req,
    input  logic [2:0]   arb_master,
    output logic         arb_ack,
    input  logic [127:0] m_addr,
    input  logic [3:0]   m_cmd,
    input  logic [127:0] m_wdata,
    output logic [3:0]   m_ack,
    output logic [3:0]   m_resp,
    output logic [3:0]   m_err,
    output logic [31:0]  m_rdata,
    output logic         s_req,
    output logic         s_cmd,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    input  logic         s_ack,
    input  logic         s_resp,
    input  logic [31:0]  s_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t       state, state_d;
    logic [1:0]   sel, sel_d;
    logic [7:0]   cnt, cnt_d;
    logic         done, done_d;
    logic         s_req_d, s_cmd_d, arb_ack_d;
    logic [31:0]  s_addr_d, s_wdata_d, m_rdata_d;
    logic [3:0]   m_ack_d, m_resp_d, m_err_d;
    logic [3:0]   sel_oh;
    logic         timeout;

    // SLAVE only labels the instance; it has no effect on behaviour.
    logic unused_slave;
    assign unused_slave = (SLAVE < 0);

    assign sel_oh  = 4'b0001 << sel;
    assign timeout = (cnt + 8'd1) == TIMEOUT;

    always_comb begin
        state_d   = state;
        sel_d     = sel;
        cnt_d     = cnt;
        done_d    = 1'b0;
        s_req_d   = s_req;
        s_cmd_d   = s_cmd;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        m_rdata_d = m_rdata;
        m_ack_d   = 4'b0000;
        m_resp_d  = 4'b0000;
        m_err_d   = 4'b0000;
        arb_ack_d = 1'b0;
        case (state)
            IDLE: begin
                // done blocks the arbiter's stale grant during the completion pulse cycle
                if (arb_req && !done && arb_master != 3'd0 && arb_master <= 3'd4) begin
                    sel_d     = 2'(arb_master - 3'd1);
                    s_addr_d  = m_addr[{sel_d, 5'd0} +: 32];
                    s_wdata_d = m_wdata[{sel_d, 5'd0} +: 32];
                    s_cmd_d   = m_cmd[sel_d];
                    s_req_d   = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (s_ack) begin
                    s_req_d   = 1'b0;
                    m_ack_d   = sel_oh;
                    arb_ack_d = 1'b1;
                    if (s_cmd) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (s_resp) begin
                        m_resp_d  = sel_oh;
                        m_rdata_d = s_rdata;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = RESP;
                    end
                end else if (timeout) begin
                    s_req_d   = 1'b0;
                    m_err_d   = sel_oh;
                    arb_ack_d = 1'b1;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            RESP: begin
                if (s_resp) begin
                    m_resp_d  = sel_oh;
                    m_rdata_d = s_rdata;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else if (timeout) begin
                    m_err_d   = sel_oh;
                    arb_ack_d = 1'b1;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sel     <= 2'd0;
            cnt     <= 8'd0;
            done    <= 1'b0;
            s_req   <= 1'b0;
            s_cmd   <= 1'b0;
            s_addr  <= 32'd0;
            s_wdata <= 32'd0;
            m_rdata <= 32'd0;
            m_ack   <= 4'b0000;
            m_resp  <= 4'b0000;
            m_err   <= 4'b0000;
            arb_ack <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            cnt     <= cnt_d;
            done    <= done_d;
            s_req   <= s_req_d;
            s_cmd   <= s_cmd_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            m_rdata <= m_rdata_d;
            m_ack   <= m_ack_d;
            m_resp  <= m_resp_d;
            m_err   <= m_err_d;
            arb_ack <= arb_ack_d;
        end
    end

endmodule

// File: tb/tb_slave_port_mux.sv
// Bench for slave_port_mux: directed and randomized transactions against a transaction-level model.
module tb_slave_port_mux;

    localparam int         TO  = 8;
    localparam logic [7:0] TMO = 8'(TO);

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         arb_req = 1'b0;
    logic [2:0]   arb_master = 3'd0;
    logic         arb_ack;
    logic [127:0] m_addr = '0;
    logic [3:0]   m_cmd = '0;
    logic [127:0] m_wdata = '0;
    logic [3:0]   m_ack, m_resp, m_err;
    logic [31:0]  m_rdata;
    logic         s_req, s_cmd;
    logic [31:0]  s_addr, s_wdata;
    logic         s_ack = 1'b0;
    logic         s_resp = 1'b0;
    logic [31:0]  s_rdata = '0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = '0;

    slave_port_mux #(.SLAVE(0), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .arb_req(arb_req), .arb_master(arb_master), .arb_ack(arb_ack),
        .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic exp_sreq, input logic [3:0] ea,
                               input logic [3:0] er, input logic [3:0] ee, input logic eab);
        chk({tag, ".s_req"},   32'(s_req),   32'(exp_sreq));
        chk({tag, ".m_ack"},   32'(m_ack),   32'(ea));
        chk({tag, ".m_resp"},  32'(m_resp),  32'(er));
        chk({tag, ".m_err"},   32'(m_err),   32'(ee));
        chk({tag, ".arb_ack"}, 32'(arb_ack), 32'(eab));
        chk({tag, ".m_rdata"}, m_rdata,      last_rdata);
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, ".s_req"},   32'(s_req),   32'd0);
        chk({tag, ".s_cmd"},   32'(s_cmd),   32'd0);
        chk({tag, ".s_addr"},  s_addr,       32'd0);
        chk({tag, ".s_wdata"}, s_wdata,      32'd0);
        chk({tag, ".m_ack"},   32'(m_ack),   32'd0);
        chk({tag, ".m_resp"},  32'(m_resp),  32'd0);
        chk({tag, ".m_err"},   32'(m_err),   32'd0);
        chk({tag, ".m_rdata"}, m_rdata,      32'd0);
        chk({tag, ".arb_ack"}, 32'(arb_ack), 32'd0);
    endtask

    task automatic scramble_masters();
        for (int i = 0; i < 4; i++) begin
            m_addr[32*i +: 32]  = $urandom;
            m_wdata[32*i +: 32] = $urandom;
            m_cmd[i]            = 1'($urandom);
        end
    endtask

    task automatic idle(input int n, input string tag);
        int bad;
        for (int i = 0; i < n; i++) begin
            bad = int'($urandom_range(0, 4));
            if (bad == 4) begin
                arb_req    = 1'b0;
                arb_master = 3'($urandom_range(1, 4));
            end else begin
                arb_req    = 1'b1;
                arb_master = (bad == 0) ? 3'd0 : 3'(bad + 4);
            end
            s_ack   = 1'($urandom);
            s_resp  = 1'($urandom);
            s_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            check_cycle(tag, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        end
        arb_req = 1'b0; arb_master = 3'd0; s_ack = 1'b0; s_resp = 1'b0;
    endtask

    // ack_at: ADDR cycle carrying s_ack (outside 1..TO means never); resp_at: RESP cycle carrying s_resp.
    task automatic run_txn(input string tag, input int m, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                           input int resp_at, input logic same, input logic early);
        logic [3:0] oh;
        oh = 4'b0001 << (m - 1);
        scramble_masters();
        m_addr[32*(m-1) +: 32]  = a;
        m_wdata[32*(m-1) +: 32] = wd;
        m_cmd[m-1]              = wr;
        arb_req    = 1'b1;
        arb_master = 3'(m);
        if (early) begin
            @(posedge clk); @(negedge clk);
            check_cycle({tag, ".blocked"}, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        end
        @(posedge clk); @(negedge clk);
        arb_req = 1'b0; arb_master = 3'd0;
        for (int j = 1; j <= TO; j++) begin
            check_cycle({tag, ".addr"}, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0);
            chk({tag, ".s_addr"},  s_addr,       a);
            chk({tag, ".s_cmd"},   32'(s_cmd),   32'(wr));
            chk({tag, ".s_wdata"}, s_wdata,      wd);
            scramble_masters();
            arb_req    = 1'($urandom);
            arb_master = 3'($urandom_range(0, 7));
            s_ack   = (j == ack_at);
            s_resp  = same && (j == ack_at);
            s_rdata = rd;
            @(posedge clk); @(negedge clk);
            s_ack = 1'b0; s_resp = 1'b0; arb_req = 1'b0; arb_master = 3'd0;
            if (j == ack_at) begin
                if (!wr && same) last_rdata = rd;
                check_cycle({tag, ".ack"}, 1'b0, oh, (!wr && same) ? oh : 4'b0, 4'b0, 1'b1);
                if (wr || same) return;
                break;
            end else if (j == TO) begin
                check_cycle({tag, ".tmo_addr"}, 1'b0, 4'b0, 4'b0, oh, 1'b1);
                return;
            end
        end
        for (int k = 1; k <= TO; k++) begin
            s_resp     = (k == resp_at);
            s_rdata    = (k == resp_at) ? rd : $urandom;
            arb_req    = 1'($urandom);
            arb_master = 3'($urandom_range(0, 7));
            @(posedge clk); @(negedge clk);
            s_resp = 1'b0; arb_req = 1'b0; arb_master = 3'd0;
            if (k == resp_at) begin
                last_rdata = rd;
                check_cycle({tag, ".resp"}, 1'b0, 4'b0, oh, 4'b0, 1'b0);
                return;
            end else if (k == TO) begin
                check_cycle({tag, ".tmo_resp"}, 1'b0, 4'b0, 4'b0, oh, 1'b1);
                return;
            end
            check_cycle({tag, ".wait"}, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        end
    endtask

    initial begin
        int   m, ack_at, resp_at;
        logic wr, same, early;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_outs("reset");
        reset_n = 1'b1;
        idle(3, "post_reset");

        // invalid grants are ignored
        arb_req = 1'b1; arb_master = 3'd0;
        @(posedge clk); @(negedge clk);
        check_cycle("grant0", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        arb_master = 3'd5;
        @(posedge clk); @(negedge clk);
        check_cycle("grant5", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        arb_req = 1'b0; arb_master = 3'd0;

        idle(1, "gap");
        run_txn("wr_m2", 2, 1'b1, 32'h10, 32'hA5A5, 32'h0, 4, 0, 1'b0, 1'b0);
        idle(1, "gap");
        run_txn("rd_m4", 4, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, 5, 1'b0, 1'b0);
        idle(2, "gap");
        run_txn("rd_same_m1", 1, 1'b0, 32'h80, 32'h0, 32'h1234_5678, 1, 0, 1'b1, 1'b0);
        idle(1, "gap");
        run_txn("tmo_addr_m3", 3, 1'b0, 32'h90, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        idle(1, "gap");
        run_txn("tmo_resp_m2", 2, 1'b0, 32'hA0, 32'h0, 32'hFFFF_0000, 3, 0, 1'b0, 1'b0);
        idle(1, "gap");
        run_txn("ack_at_limit", 1, 1'b1, 32'hB0, 32'h77, 32'h0, TO, 0, 1'b0, 1'b0);
        run_txn("early_grant", 3, 1'b0, 32'hC0, 32'h0, 32'hCAFE_F00D, 1, TO, 1'b0, 1'b1);

        // reset in the response phase abandons the transaction
        idle(1, "gap");
        scramble_masters();
        m_addr[63:32] = 32'h55; m_cmd[1] = 1'b0;
        arb_req = 1'b1; arb_master = 3'd2;
        @(posedge clk); @(negedge clk);
        arb_req = 1'b0; arb_master = 3'd0;
        chk("rst_txn.s_req", 32'(s_req), 32'd1);
        s_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        s_ack = 1'b0;
        check_cycle("rst_txn.ack", 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        #1 reset_n = 1'b0;
        #1 reset_outs("reset_mid");
        last_rdata = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        s_resp = 1'b1; s_rdata = 32'hBAD0_BAD0;
        @(posedge clk); @(negedge clk);
        s_resp = 1'b0;
        check_cycle("late_resp", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        run_txn("after_reset", 2, 1'b0, 32'hD0, 32'h0, 32'h0BAD_CAFE, 1, 2, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            m       = int'($urandom_range(1, 4));
            wr      = 1'($urandom);
            ack_at  = int'($urandom_range(1, TO + 1));
            resp_at = int'($urandom_range(1, TO + 1));
            same    = ($urandom_range(0, 3) == 0);
            early   = 1'($urandom);
            if (!early) idle(int'($urandom_range(1, 3)), "rand_gap");
            run_txn("rand", m, wr, $urandom, $urandom, $urandom, ack_at, resp_at, same, early);
        end
        idle(2, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
